// File: rtl/apb_gpio_slave.sv
// apb_gpio_slave: APB GPIO port with DOUT/DIR/DIN registers and a fixed
// three-cycle transfer (setup, wait-state access, completing access).
// Optional edge-detecting interrupt unit, built when GPIO_IRQ_EN is defined.
module apb_gpio_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int GPIO_WIDTH   = 32
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [STROBE_WIDTH-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  output logic [GPIO_WIDTH-1:0]   gpio_oe,
  output logic                    irq
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

  state_t                  state_q, phase, state_nxt;
  logic [2:0]              addr_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STROBE_WIDTH-1:0] strb_q;
  logic                    err, commit, done;
  logic [GPIO_WIDTH-1:0]   dout_q, dir_q, s1_q, s2_q, rd_val, wmask, wdata_g;
  logic [DATA_WIDTH-1:0]   wmask_full;
  logic                    unused_bits;
`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0]   s3_q, imask_q, iedge_q, istat_q, rise, fall, set_evt, clr;
`endif

  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0], PPROT};

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state: a setup phase arriving while idle is that cycle's SETUP,
  // so DONE lands on the second access cycle of the bus transfer
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && PSEL && !PENABLE) phase = SETUP;
    state_nxt = IDLE;
    if (PSEL) begin
      case (phase)
        IDLE:    state_nxt = IDLE;
        SETUP:   state_nxt = WAIT;
        WAIT:    state_nxt = DONE;
        DONE:    state_nxt = PENABLE ? IDLE : SETUP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bus outputs, driven only in the completing cycle
  always_comb begin
    done    = (state_q == DONE);
    PREADY  = done;
    PSLVERR = done && err;
    PRDATA  = '0;
    if (done && !wr_q && !err) PRDATA[GPIO_WIDTH-1:0] = rd_val;
  end

  // Capture the transfer attributes as it leaves SETUP
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (phase == SETUP && PSEL) begin
      addr_q  <= PADDR[4:2];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Register decode: read mux and error detection
  always_comb begin
    err    = 1'b0;
    rd_val = '0;
    case (addr_q)
      3'd0: rd_val = dout_q;
      3'd1: rd_val = dir_q;
      3'd2: begin
        rd_val = s2_q;
        err    = wr_q;
      end
`ifdef GPIO_IRQ_EN
      3'd3: rd_val = imask_q;
      3'd4: rd_val = istat_q;
      3'd5: rd_val = iedge_q;
`endif
      default: err = 1'b1;
    endcase
  end

  assign commit = done && wr_q && !err;

  // Expand byte strobes into a bit mask
  always_comb begin
    wmask_full = '0;
    for (int unsigned i = 0; i < STROBE_WIDTH; i++)
      wmask_full[i*8 +: 8] = {8{strb_q[i]}};
  end

  assign wmask   = wmask_full[GPIO_WIDTH-1:0];
  assign wdata_g = wdata_q[GPIO_WIDTH-1:0];

  // DOUT and DIR registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      dout_q <= '0;
      dir_q  <= '0;
    end else if (commit) begin
      if (addr_q == 3'd0) dout_q <= (dout_q & ~wmask) | (wdata_g & wmask);
      if (addr_q == 3'd1) dir_q  <= (dir_q  & ~wmask) | (wdata_g & wmask);
    end
  end

  // Input synchroniser (plus edge-history flop when interrupts exist)
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      s1_q <= '0;
      s2_q <= '0;
`ifdef GPIO_IRQ_EN
      s3_q <= '0;
`endif
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
`ifdef GPIO_IRQ_EN
      s3_q <= s2_q;
`endif
    end
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign set_evt = (rise & iedge_q) | (fall & ~iedge_q);
  assign clr     = (commit && addr_q == 3'd4) ? (wdata_g & wmask) : '0;

  // IMASK and IEDGE registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      imask_q <= '0;
      iedge_q <= '0;
    end else if (commit) begin
      if (addr_q == 3'd3) imask_q <= (imask_q & ~wmask) | (wdata_g & wmask);
      if (addr_q == 3'd5) iedge_q <= (iedge_q & ~wmask) | (wdata_g & wmask);
    end
  end

  // ISTAT: a new edge event takes priority over a same-cycle W1C clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) istat_q <= '0;
    else        istat_q <= (istat_q & ~clr) | set_evt;
  end

  assign irq = |(istat_q & imask_q);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed self-checking bench for apb_gpio_slave. Interrupt scenarios are
// exercised when GPIO_IRQ_EN is defined, the disabled decode otherwise.
module tb_apb_gpio_slave;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int GW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [DW-1:0] PWDATA = '0;
  logic [SW-1:0] PSTRB = '0;
  logic [2:0]    PPROT = 3'b000;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] gpio_out;
  logic [GW-1:0] gpio_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STROBE_WIDTH(SW), .GPIO_WIDTH(GW)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // One APB transfer; pins are applied to gpio_in in the setup cycle.
  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [GW-1:0] pins,
                     output logic [31:0] rd, output logic e, output int lat);
    @(posedge PCLK); #1;
    gpio_in = pins;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 1;
    while (PREADY !== 1'b1 && lat < 8) begin
      @(posedge PCLK); #1;
      lat++;
    end
    rd = PRDATA;
    e  = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic e);
    logic [31:0] r;
    int l;
    apb(1'b1, a, d, s, gpio_in, r, e, l);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output logic e);
    int l;
    apb(1'b0, a, 32'h0, 4'h0, gpio_in, r, e, l);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic e;
    #2 PRESET = 1'b1;
    #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b want 0", PREADY); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", PSLVERR); end
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h want 0", PRDATA); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL rst_gpio_out: got %h want 0", gpio_out); end
    checks++; if (gpio_oe !== 32'h0) begin errors++; $display("FAIL rst_gpio_oe: got %h want 0", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    @(posedge PCLK); #1 PRESET = 1'b0;
    // write 0xFFFFFFFF to DOUT, reset lands in the wait cycle
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL midrst_pready: got %b want 0", PREADY); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL midrst_gpio_out: got %h want 0", gpio_out); end
    @(posedge PCLK); #1;
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL midrst_hold_gpio_out: got %h want 0", gpio_out); end
    checks++; if (PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin errors++; $display("FAIL midrst_bus: got err %b data %h want 0 0", PSLVERR, PRDATA); end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1 PRESET = 1'b0;
    rd(32'h0, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_dout_read: got %h want 0", r); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL rst_gpio_out_after: got %h want 0", gpio_out); end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic e;
    int l;
    apb(1'b1, 32'h00, 32'hFF00_0F00, 4'hF, gpio_in, r, e, l);
    checks++; if (l !== 2) begin errors++; $display("FAIL ready_latency: got %0d want 2", l); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL dout_wr_err: got %b want 0", e); end
    checks++; if (gpio_out !== 32'hFF00_0F00) begin errors++; $display("FAIL gpio_out: got %h want ff000f00", gpio_out); end
    apb(1'b1, 32'h04, 32'h0000_FFFF, 4'hF, gpio_in, r, e, l);
    checks++; if (gpio_oe !== 32'h0000_FFFF) begin errors++; $display("FAIL gpio_oe: got %h want 0000ffff", gpio_oe); end
    rd(32'h00, r, e);
    checks++; if (r !== 32'hFF00_0F00) begin errors++; $display("FAIL dout_read: got %h want ff000f00", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL dout_read_err: got %b want 0", e); end
    rd(32'h04, r, e);
    checks++; if (r !== 32'h0000_FFFF) begin errors++; $display("FAIL dir_read: got %h want 0000ffff", r); end
  endtask

  task automatic test_strobes();
    logic [31:0] r;
    logic e;
    wr(32'h00, 32'h0, 4'hF, e);
    wr(32'h00, 32'h1234_5678, 4'b0101, e);
    rd(32'h00, r, e);
    checks++; if (r !== 32'h0034_0078) begin errors++; $display("FAIL strb_0101: got %h want 00340078", r); end
    wr(32'h00, 32'hFFFF_FFFF, 4'h0, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL strb_0_err: got %b want 0", e); end
    rd(32'h00, r, e);
    checks++; if (r !== 32'h0034_0078) begin errors++; $display("FAIL strb_0_nochange: got %h want 00340078", r); end
    rd(32'h03, r, e);
    checks++; if (r !== 32'h0034_0078) begin errors++; $display("FAIL addr_low_ignored: got %h want 00340078", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r;
    logic e;
    gpio_in = 32'h0000_00A5;
    repeat (3) @(posedge PCLK);
    wr(32'h08, 32'h1, 4'hF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL din_write_err: got %b want 1", e); end
    rd(32'h08, r, e);
    checks++; if (r !== 32'h0000_00A5 || e !== 1'b0) begin errors++; $display("FAIL din_read: got %h err %b want 000000a5 0", r, e); end
    rd(32'h18, r, e);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL bad_offset_read: got %h err %b want 0 1", r, e); end
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_offset_write_err: got %b want 1", e); end
    rd(32'h00, r, e);
    checks++; if (r !== 32'h0034_0078) begin errors++; $display("FAIL err_no_side_effect: got %h want 00340078", r); end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic e;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b want 0", PREADY); end
    repeat (2) @(posedge PCLK);
    #1;
    checks++; if (gpio_out !== 32'h0034_0078) begin errors++; $display("FAIL abort_gpio_out: got %h want 00340078", gpio_out); end
    rd(32'h00, r, e);
    checks++; if (r !== 32'h0034_0078) begin errors++; $display("FAIL abort_dout: got %h want 00340078", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    logic w, exp_rdy;
    for (int k = 0; k < 9; k++) begin
      @(posedge PCLK); #1;
      case (k / 3)
        0:       begin a = 32'h00; w = 1'b1; d = 32'hA5A5_0001; end
        1:       begin a = 32'h04; w = 1'b1; d = 32'h0000_00FF; end
        default: begin a = 32'h00; w = 1'b0; d = 32'h0; end
      endcase
      PSEL = 1'b1; PENABLE = (k % 3 != 0); PADDR = a; PWRITE = w; PWDATA = d; PSTRB = 4'hF;
      #1;
      exp_rdy = (k % 3 == 2);
      checks++; if (PREADY !== exp_rdy) begin errors++; $display("FAIL b2b_pready[%0d]: got %b want %b", k, PREADY, exp_rdy); end
      if (k == 8) begin
        checks++; if (PRDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_read: got %h want a5a50001", PRDATA); end
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    checks++; if (gpio_oe !== 32'h0000_00FF) begin errors++; $display("FAIL b2b_gpio_oe: got %h want 000000ff", gpio_oe); end
    checks++; if (gpio_out !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_gpio_out: got %h want a5a50001", gpio_out); end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] r;
    logic e;
    int l;
    gpio_in = '0;
    repeat (4) @(posedge PCLK);
    wr(32'h14, 32'h1, 4'hF, e);
    wr(32'h10, 32'hFFFF_FFFF, 4'hF, e);
    wr(32'h0C, 32'h1, 4'hF, e);
    rd(32'h10, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL istat_cleared: got %h want 0", r); end
    rd(32'h14, r, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL iedge_read: got %h want 1", r); end
    rd(32'h0C, r, e);
    checks++; if (r !== 32'h1 || e !== 1'b0) begin errors++; $display("FAIL imask_read: got %h err %b want 1 0", r, e); end
    // pin rises in the setup cycle of a DIN read
    @(posedge PCLK); #1;
    gpio_in[0] = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h08;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_edge1: got %b want 0", irq); end
    @(posedge PCLK); #1;
    checks++; if (PREADY !== 1'b1 || PRDATA !== 32'h1) begin errors++; $display("FAIL din_latency: got rdy %b data %h want 1 00000001", PREADY, PRDATA); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_edge2: got %b want 0", irq); end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_edge3: got %b want 1", irq); end
    rd(32'h10, r, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL istat_set: got %h want 1", r); end
    wr(32'h10, 32'h1, 4'h0, e);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_no_strobe: got %b want 1", irq); end
    wr(32'h10, 32'h1, 4'hF, e);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
    // falling edge not selected for bit 0
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_ignored: got %b want 0", irq); end
    // bit 1 rising with its mask clear: status set, no irq
    wr(32'h14, 32'h3, 4'hF, e);
    gpio_in[1] = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b want 0", irq); end
    rd(32'h10, r, e);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL masked_istat: got %h want 2", r); end
    wr(32'h10, 32'h2, 4'hF, e);
    // set wins over a same-cycle W1C
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge PCLK);
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    apb(1'b1, 32'h10, 32'h1, 4'hF, gpio_in | 32'h1, r, e, l);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    rd(32'h10, r, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL set_wins_istat: got %h want 1", r); end
  endtask
`else
  task automatic test_no_irq();
    logic [31:0] r;
    logic e;
    rd(32'h10, r, e);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL noirq_istat: got %h err %b want 0 1", r, e); end
    rd(32'h0C, r, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL noirq_imask_err: got %b want 1", e); end
    wr(32'h14, 32'h1, 4'hF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL noirq_iedge_err: got %b want 1", e); end
    for (int k = 0; k < 6; k++) begin
      @(posedge PCLK); #1;
      gpio_in = ~gpio_in;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL noirq_irq[%0d]: got %b want 0", k, irq); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_errors();
    test_abort();
    test_back_to_back();
`ifdef GPIO_IRQ_EN
    test_irq();
`else
    test_no_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
# apb_gpio_slave

APB slave that sits directly downstream of the APB bus master and is selected by one bit of its PSEL vector. Exposes a memory-mapped general-purpose I/O port: output data and direction registers, a synchronised input register and, optionally, an edge-detecting interrupt unit. Every transfer completes in three PCLK cycles: one setup cycle and two access cycles, with one fixed wait state.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- ADDR_WIDTH, 32, PADDR width. Only PADDR[4:2] is decoded; PADDR[1:0] is ignored.
- STROBE_WIDTH, 4, PSTRB width, equal to DATA_WIDTH/8.
- GPIO_WIDTH, 32, number of pins, at most DATA_WIDTH. Register bits at and above GPIO_WIDTH read 0 and ignore writes.

Ports:
- PCLK  in  1  bus clock; all state changes on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select (one bit of the master's PSEL vector).
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STROBE_WIDTH  byte write enables.
- PPROT  in  3  protection attributes; accepted and ignored.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response.
- gpio_in  in  GPIO_WIDTH  asynchronous pin inputs.
- gpio_out  out  GPIO_WIDTH  pin output values.
- gpio_oe  out  GPIO_WIDTH  per-pin output enable (1 = drive).
- irq  out  1  level interrupt.

## Operation
Register map (byte offset):
- 0x00 DOUT, RW; drives gpio_out.
- 0x04 DIR, RW; drives gpio_oe.
- 0x08 DIN, RO; synchronised gpio_in.
- 0x0C IMASK, RW.
- 0x10 ISTAT, RW1C.
- 0x14 IEDGE, RW; per bit, 1 = rising edge, 0 = falling edge.

FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE→SETUP when PSEL=1 and PENABLE=0.
- SETUP→WAIT when PSEL=1 and PENABLE=1. Address, direction, data and strobes are latched here.
- WAIT→DONE unconditionally.
- DONE→SETUP if PSEL=1 and PENABLE=0; otherwise DONE→IDLE.
- Any state→IDLE if PSEL=0. A transfer abandoned before DONE commits nothing.

Completion:
- PREADY=1 only in DONE.
- PRDATA holds the read value only in DONE for an error-free read; otherwise it is 0.
- PSLVERR=1 only in DONE, and only for these errors: an offset of 0x18 or above, or a write to DIN.
- An errored transfer changes no register state.

Writes:
- Committed at the end of DONE.
- Byte lane i updates only when PSTRB[i]=1. PSTRB=0 completes normally with no change.
- ISTAT write: each bit written 1 (with its lane enabled) clears that status bit.

Input path:
- gpio_in passes through a 2-flop synchroniser (s2); DIN = s2.
- A third flop, s3, feeds edge detection.
- Rise = s2 & ~s3; fall = ~s2 & s3.

Interrupts:
- ISTAT bit sets on the edge selected by IEDGE.
- A set event and a W1C clear on the same bit in the same cycle: set wins.
- irq = |(ISTAT & IMASK), combinational from registers.

## Timing
- Reset (PRESET=1, asynchronous):
  - FSM goes to IDLE.
  - All registers and synchroniser flops = 0.
  - gpio_out=0, gpio_oe=0, irq=0, PREADY=0, PSLVERR=0, PRDATA=0.
- Reset asserted mid-transfer aborts it; no write commits.
- Transfer: setup cycle, PREADY=0 access cycle, PREADY=1 access cycle. Back-to-back transfers run every 3 cycles.
- A write is visible on gpio_out/gpio_oe from the first cycle after DONE.
- Pin-to-DIN latency: 2 PCLK edges. Pin-to-ISTAT/irq latency: 3 PCLK edges.
- A read of ISTAT returns the value at the DONE cycle.

## Configuration
- GPIO_IRQ_EN defined:
  - IMASK, ISTAT and IEDGE are implemented.
  - irq operates as above.
- GPIO_IRQ_EN undefined:
  - s3 and all interrupt logic are absent.
  - Offsets 0x0C–0x14 decode as invalid (PSLVERR=1, PRDATA=0).
  - irq is tied to 0.

## Test plan
- Reset checks:
  - Assert PRESET mid-WAIT of a write of 0xFFFFFFFF to DOUT -> gpio_out stays 0 and all outputs are 0 during reset.
  - Deassert reset, then read DOUT -> 0.
- Basic write/read: write 0xFF000F00 to 0x00 and 0x0000FFFF to 0x04 with PSTRB=0xF -> PREADY high exactly 2 cycles after PSEL rises; next cycle gpio_out=0xFF000F00 and gpio_oe=0x0000FFFF; read of 0x00 returns 0xFF000F00 with PSLVERR=0.
- Byte strobes: write 0x12345678 to 0x00 with PSTRB=0b0101 over existing 0 -> DOUT reads 0x00340078. Write with PSTRB=0 -> DOUT unchanged.
- Errors:
  - Write 0x1 to 0x08 -> PSLVERR=1 in DONE, and a subsequent read of DIN still equals the pins.
  - Read 0x18 -> PSLVERR=1, PRDATA=0.
- Input and interrupt (GPIO_IRQ_EN):
  - Set IMASK=0x1 and IEDGE=0x1, then raise gpio_in[0] -> DIN[0]=1 after 2 edges; ISTAT[0]=1 and irq=1 after 3 edges.
  - Write 0x1 to 0x10 -> irq=0.
  - A second rising edge landing in the W1C commit cycle -> ISTAT[0] stays 1.
- Without GPIO_IRQ_EN: read 0x10 -> PSLVERR=1; toggle gpio_in -> irq stays 0.
